// File: rtl/level_bg_fetch.sv
// rtl/level_bg_fetch.sv - level background fetch: beam+scroll to ROM address, index capture, sync delay
// Scroll offset only changes on frame_start so a frame never tears.
module level_bg_fetch #(
  parameter int LVL_W   = 320,
  parameter int LVL_H   = 240,
  parameter int ROM_LAT = 1,
  parameter int ADDR_W  = 17
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              de_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              frame_start,
  input  logic [3:0]        scroll_step,
  input  logic              scroll_valid,
  output logic              scroll_ready,
  output logic [8:0]        scroll_x,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        pix_index,
  output logic              de_out,
  output logic              hs_out,
  output logic              vs_out
);

  logic [8:0]        xh, yh;
  logic [9:0]        xs_sum, xs;
  logic [ADDR_W-1:0] addr_next;
  logic              blank;

  logic              pending;
  logic [3:0]        pend_step;
  logic [9:0]        sx_sum;
  logic [8:0]        sx_next;

  // index 0 is the address stage; index ROM_LAT lines up with rom_q
  logic [ROM_LAT:0]  de_p, hs_p, vs_p;

  assign xh = DrawX[9:1];
  assign yh = DrawY[9:1];

  // both operands are below LVL_W, so one conditional subtract wraps
  always_comb begin
    xs_sum    = {1'b0, xh} + {1'b0, scroll_x};
    xs        = (xs_sum >= 10'(LVL_W)) ? xs_sum - 10'(LVL_W) : xs_sum;
    blank     = !de_in || (yh >= 9'(LVL_H));
    addr_next = ADDR_W'(yh) * ADDR_W'(LVL_W) + ADDR_W'(xs);
  end

  always_comb begin
    sx_sum  = {1'b0, scroll_x} + {6'b0, pend_step};
    sx_next = (sx_sum >= 10'(LVL_W)) ? 9'(sx_sum - 10'(LVL_W)) : sx_sum[8:0];
  end

  assign scroll_ready = !pending;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr  <= '0;
      de_p      <= '0;
      hs_p      <= '1;
      vs_p      <= '1;
      pix_index <= '0;
      de_out    <= 1'b0;
      hs_out    <= 1'b1;
      vs_out    <= 1'b1;
    end else begin
      rom_addr <= blank ? '0 : addr_next;
      de_p[0]  <= de_in;
      hs_p[0]  <= hs_in;
      vs_p[0]  <= vs_in;
      for (int i = 1; i <= ROM_LAT; i++) begin
        de_p[i] <= de_p[i-1];
        hs_p[i] <= hs_p[i-1];
        vs_p[i] <= vs_p[i-1];
      end
      pix_index <= de_p[ROM_LAT] ? rom_q : 4'd0;
      de_out    <= de_p[ROM_LAT];
      hs_out    <= hs_p[ROM_LAT];
      vs_out    <= vs_p[ROM_LAT];
    end
  end

  // apply and accept are exclusive: accept needs pending low, apply needs it high
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pending   <= 1'b0;
      pend_step <= '0;
      scroll_x  <= '0;
    end else if (pending) begin
      if (frame_start) begin
        scroll_x <= sx_next;
        pending  <= 1'b0;
      end
    end else if (scroll_valid) begin
      pending   <= 1'b1;
      pend_step <= scroll_step;
    end
  end

endmodule

// File: tb/tb_level_bg_fetch.sv
// tb/tb_level_bg_fetch.sv - directed self-checking bench for level_bg_fetch
module tb_level_bg_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        de_in, hs_in, vs_in, frame_start;
  logic [3:0]  scroll_step;
  logic        scroll_valid;
  logic        scroll_ready;
  logic [8:0]  scroll_x;
  logic [16:0] rom_addr;
  logic [3:0]  rom_q = 4'd0;
  logic [3:0]  pix_index;
  logic        de_out, hs_out, vs_out;

  int n_checks = 0;
  int n_pass   = 0;

  level_bg_fetch dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in), .frame_start(frame_start),
    .scroll_step(scroll_step), .scroll_valid(scroll_valid),
    .scroll_ready(scroll_ready), .scroll_x(scroll_x), .rom_addr(rom_addr),
    .rom_q(rom_q), .pix_index(pix_index), .de_out(de_out), .hs_out(hs_out),
    .vs_out(vs_out)
  );

  always #5 Clk = ~Clk;

  // one-cycle-latency ROM returning the low address nibble
  always @(posedge Clk) rom_q <= rom_addr[3:0];

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_step(input logic [3:0] s);
    scroll_step = s; scroll_valid = 1'b1;
    tick();
    scroll_valid = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    logic hs_pat [0:9];
    logic vs_pat [0:9];

    Reset = 1'b1; DrawX = '0; DrawY = '0; de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    frame_start = 1'b0; scroll_step = '0; scroll_valid = 1'b0;
    tick(); tick();
    check("rst_rom_addr", rom_addr, 0);
    check("rst_pix", pix_index, 0);
    check("rst_de", de_out, 0);
    check("rst_hs", hs_out, 1);
    check("rst_vs", vs_out, 1);
    check("rst_scroll_x", scroll_x, 0);
    check("rst_ready", scroll_ready, 1);
    Reset = 1'b0;

    // pixel stream: origin, far corner, pair 10/11, then blanked
    DrawX = 0; DrawY = 0; de_in = 1'b1;
    tick();
    check("origin_addr", rom_addr, 0);
    DrawX = 639; DrawY = 479;
    tick();
    check("corner_addr", rom_addr, 76799);
    DrawX = 10; DrawY = 0;
    tick();
    check("x10_addr", rom_addr, 5);
    check("origin_pix", pix_index, 0);
    check("origin_de", de_out, 1);
    DrawX = 11;
    tick();
    check("x11_addr", rom_addr, 5);
    check("corner_pix", pix_index, 15);
    de_in = 1'b0; DrawX = 100;
    tick();
    check("blank_addr", rom_addr, 0);
    check("x10_pix", pix_index, 5);
    tick();
    check("x11_pix", pix_index, 5);
    check("x11_de", de_out, 1);
    tick();
    check("blank_pix", pix_index, 0);
    check("blank_de", de_out, 0);

    // hs low for 4 cycles, vs low for 2, both reappear 3 edges later
    for (int i = 0; i < 10; i++) begin
      hs_pat[i] = !(i >= 1 && i < 5);
      vs_pat[i] = !(i >= 1 && i < 3);
    end
    for (int i = 0; i < 10; i++) begin
      hs_in = hs_pat[i]; vs_in = vs_pat[i];
      tick();
      check($sformatf("hs_dly%0d", i), hs_out, (i >= 2) ? hs_pat[i-2] : 1'b1);
      check($sformatf("vs_dly%0d", i), vs_out, (i >= 2) ? vs_pat[i-2] : 1'b1);
    end
    hs_in = 1'b1; vs_in = 1'b1;

    // scroll handshake: second request while pending is dropped
    scroll_step = 5; scroll_valid = 1'b1;
    tick();
    check("acc_ready_low", scroll_ready, 0);
    check("acc_no_apply", scroll_x, 0);
    scroll_step = 9;
    tick();
    scroll_valid = 1'b0;
    check("pend_ready_low", scroll_ready, 0);
    check("pend_x_hold", scroll_x, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("apply5_x", scroll_x, 5);
    check("apply5_ready", scroll_ready, 1);
    DrawX = 2; DrawY = 0; de_in = 1'b1;
    tick();
    check("scroll5_addr", rom_addr, 6);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("dropped_step", scroll_x, 5);

    // frame_start with empty pending: accepted, applied on the next frame
    frame_start = 1'b1; scroll_valid = 1'b1; scroll_step = 3;
    tick();
    frame_start = 1'b0; scroll_valid = 1'b0;
    check("simul_x_hold", scroll_x, 5);
    check("simul_ready_low", scroll_ready, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("simul_apply", scroll_x, 8);

    // walk to 318 (8 + 20*15 + 10), then wrap
    for (int i = 0; i < 20; i++) apply_step(15);
    apply_step(10);
    check("x318", scroll_x, 318);
    DrawX = 4; DrawY = 0; de_in = 1'b1;
    tick();
    check("wrap_addr", rom_addr, 0);
    DrawX = 2; DrawY = 2;
    tick();
    check("x318_addr", rom_addr, 320 + 319);
    apply_step(5);
    check("wrap_x", scroll_x, 3);

    // reach 40, leave a request pending, reset with pixels in flight
    apply_step(15); apply_step(15); apply_step(7);
    check("x40", scroll_x, 40);
    scroll_step = 9; scroll_valid = 1'b1; DrawX = 20; DrawY = 4; de_in = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
    tick();
    scroll_valid = 1'b0;
    tick();
    check("pre_rst_ready", scroll_ready, 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0; de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    check("mrst_x", scroll_x, 0);
    check("mrst_ready", scroll_ready, 1);
    check("mrst_de", de_out, 0);
    check("mrst_hs", hs_out, 1);
    check("mrst_vs", vs_out, 1);
    check("mrst_pix", pix_index, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("mrst_frame_x", scroll_x, 0);
    check("mrst_frame_ready", scroll_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
